// File: rtl/mmio_uart_tx_if.sv
// Data-memory style bus between the core (master) and an MMIO responder (slave):
// store strobe, byte lanes, byte address, store data and combinational read data.
interface mmio_uart_tx_if;
  logic        we;
  logic [3:0]  byteEnable;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, byteEnable, a, wd, input rd);
  modport slave  (input we, byteEnable, a, wd, output rd);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a TX FIFO that a serializer drains.
// Defining UART_TX_IRQ_EN adds the IRQEN register at offset 3 and a level irq output.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic           irq
`endif
);

  localparam int             PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;
  localparam logic [1:0] OFF_IRQEN   = 2'd3;

  logic          w_sel;
  logic [1:0]    w_off;
  logic          w_wr_tx, w_wr_status, w_wr_div;
  logic          w_full, w_empty, w_push, w_pop, w_ovf_set, w_ovf_clr;
  logic          w_busy, w_baud_done;
  logic [15:0]   w_div_m1;
  logic [7:0]    w_head;
  logic [31:0]   w_count_ext;
  logic [3:0]    w_count_sat;
  logic [31:0]   w_status;
  logic          w_unused;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic [15:0]   r_div;
  logic [1:0]    r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_tx;

  assign w_sel       = (bus.a[31:4] == BASE_ADDR[31:4]);
  assign w_off       = bus.a[3:2];
  assign w_wr_tx     = bus.we & w_sel & (w_off == OFF_TXDATA)  & bus.byteEnable[0];
  assign w_wr_status = bus.we & w_sel & (w_off == OFF_STATUS)  & bus.byteEnable[0];
  assign w_wr_div    = bus.we & w_sel & (w_off == OFF_BAUDDIV);
  assign w_unused    = ^{bus.a[1:0], bus.wd[31:16], bus.byteEnable[3:2]};

  // Full/empty come from the pre-edge count, so a same-cycle pop never makes room.
  assign w_full      = (r_count == DEPTH_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = w_wr_tx & ~w_full;
  assign w_ovf_set   = w_wr_tx & w_full;
  assign w_ovf_clr   = w_wr_status & bus.wd[3];
  assign w_head      = r_mem[r_rd_ptr];

  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_done = (r_baud == 16'd0);
  assign w_div_m1    = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_done));

  // NOTE: FIFO storage has no reset; the pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wd[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_div <= DEFAULT_DIV;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr_div && bus.byteEnable[0]) r_div[7:0]  <= bus.wd[7:0];
      if (w_wr_div && bus.byteEnable[1]) r_div[15:8] <= bus.wd[15:8];
    end
  end

  // The baud counter reloads from BAUDDIV at every bit boundary, which is where a new divisor lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_baud   <= 16'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= w_div_m1;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_tx     <= r_shift[0];
            r_bitcnt <= 3'd0;
            r_baud   <= w_div_m1;
            r_state  <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= w_div_m1;
            if (r_bitcnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_baud  <= w_div_m1;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx = r_tx;

  assign w_count_ext = 32'(r_count);
  assign w_count_sat = (w_count_ext > 32'd15) ? 4'hF : w_count_ext[3:0];
  assign w_status    = {24'd0, w_count_sat, r_ovf, w_busy, w_empty, w_full};

`ifdef UART_TX_IRQ_EN
  logic w_wr_irqen;
  logic r_irqen;
  logic r_irq;

  assign w_wr_irqen = bus.we & w_sel & (w_off == OFF_IRQEN) & bus.byteEnable[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_irqen) r_irqen <= bus.wd[0];
      r_irq <= r_irqen & w_empty & ~w_busy;
    end
  end

  assign irq = r_irq;
`endif

  // NOTE: rd gets a default before the case so the read mux cannot infer a latch.
  always_comb begin
    bus.rd = 32'd0;
    if (w_sel) begin
      case (w_off)
        OFF_STATUS:  bus.rd = w_status;
        OFF_BAUDDIV: bus.rd = {16'd0, r_div};
`ifdef UART_TX_IRQ_EN
        OFF_IRQEN:   bus.rd = {31'd0, r_irqen};
`endif
        default:     bus.rd = 32'd0;
      endcase
    end
  end

endmodule
